// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Boot-time program loader. Holds the core in reset, receives a
//               framed byte stream (length, little-endian words, XOR checksum)
//               over valid/ready, writes the words into instruction memory at
//               consecutive word addresses, and releases the core once the
//               checksum matches.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  // Largest accepted word count, widened to the count register width.
  localparam logic [31:0] C_MAX_WORDS = 32'(MAX_WORDS);
  // words_loaded stops counting here rather than wrapping.
  localparam logic [15:0] C_WORDS_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Frame bookkeeping
  logic [1:0]  r_byte_cnt;      // byte lane within the current length/data word
  logic [31:0] r_len;           // word count N, assembled from the length field
  logic [31:0] r_asm;           // data word under assembly
  logic [15:0] r_word_cnt;      // words fully assembled in this load
  logic [7:0]  r_xor;           // running XOR of length and data bytes

  // Memory write port (separate from the assembly register so the stream
  // never has to stall while a completed word is being written)
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [15:0] r_words_loaded;

  logic        w_rx_ready;
  logic        w_accept;
  logic        w_start_ok;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_csum_ok;
  logic [31:0] w_len_next;
  logic [31:0] w_word;
  logic [31:0] w_word_addr;
  logic [15:0] w_words_inc;

  // Handshake and frame-position decode
  assign w_rx_ready  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_accept    = rx_valid && w_rx_ready;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = (({16'd0, r_word_cnt} + 32'd1) == r_len);
  assign w_csum_ok   = (rx_data == r_xor);

  // Address of the next word written: base plus four bytes per word already
  // counted; the sum wraps naturally at 32 bits.
  assign w_word_addr = BASE_ADDR + {14'd0, r_words_loaded, 2'b00};
  assign w_words_inc = (r_words_loaded == C_WORDS_SAT) ? r_words_loaded
                                                       : (r_words_loaded + 16'd1);

  // Insert the incoming byte into its lane of the length and data registers
  always_comb begin
    w_len_next = r_len;
    w_word     = r_asm;
    w_len_next[{r_byte_cnt, 3'b000} +: 8] = rx_data;
    w_word[{r_byte_cnt, 3'b000} +: 8]     = rx_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (w_accept && w_last_byte) begin
          if (w_len_next > C_MAX_WORDS) begin
            w_state_next = S_ERROR;
          end else if (w_len_next == 32'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept && w_last_byte && w_last_word) begin
          w_state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          w_state_next = w_csum_ok ? S_DONE : S_ERROR;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Length capture, word assembly and checksum accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= 2'd0;
      r_len      <= 32'd0;
      r_asm      <= 32'd0;
      r_word_cnt <= 16'd0;
      r_xor      <= 8'd0;
    end else if (w_start_ok) begin
      r_byte_cnt <= 2'd0;
      r_len      <= 32'd0;
      r_asm      <= 32'd0;
      r_word_cnt <= 16'd0;
      r_xor      <= 8'd0;
    end else if (w_accept) begin
      case (r_state)
        S_LEN: begin
          r_len      <= w_len_next;
          r_xor      <= r_xor ^ rx_data;
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        S_DATA: begin
          r_asm      <= w_word;
          r_xor      <= r_xor ^ rx_data;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (w_last_byte) begin
            r_word_cnt <= r_word_cnt + 16'd1;
          end
        end
        default: begin
          // The checksum byte is compared, never folded into the XOR.
        end
      endcase
    end
  end

  // Memory write: a completed word is presented for exactly one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we           <= 1'b0;
      r_addr         <= BASE_ADDR;
      r_wd           <= 32'd0;
      r_words_loaded <= 16'd0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_words_loaded <= 16'd0;
      end else if (w_accept && (r_state == S_DATA) && w_last_byte) begin
        r_we           <= 1'b1;
        r_addr         <= w_word_addr;
        r_wd           <= w_word;
        r_words_loaded <= w_words_inc;
      end
    end
  end

  assign rx_ready     = w_rx_ready;
  assign busy         = w_rx_ready;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wd      = r_wd;
  assign words_loaded = r_words_loaded;
  assign done         = (r_state == S_DONE);
  assign error        = (r_state == S_ERROR);
  // The core only leaves reset once a verified image is in memory.
  assign core_rst     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Self-checking bench for instr_loader. A frame-level model
//               tracks what the loader must present each cycle; directed
//               literal checks pin the model on the nominal images.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        start    = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  wire         rx_ready;
  wire         imem_we;
  wire  [31:0] imem_addr;
  wire  [31:0] imem_wd;
  wire         core_rst;
  wire         busy;
  wire         done;
  wire         error;
  wire  [15:0] words_loaded;

  instr_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wd      (imem_wd),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit          m_act   = 1'b0;  // loader is taking frame bytes
  bit          m_done  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_we    = 1'b0;
  logic [31:0] m_addr  = BASE;
  logic [31:0] m_wd    = 32'd0;
  logic [15:0] m_words = 16'd0;
  logic [31:0] m_len   = 32'd0;
  logic [31:0] m_word  = 32'd0;
  logic [7:0]  m_xor   = 8'd0;
  int          m_nb    = 0;     // frame bytes accepted so far

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_act = 0; m_done = 0; m_err = 0; m_we = 0;
        m_addr = BASE; m_wd = 32'd0; m_words = 16'd0;
      end else begin
        m_we = 0;
        if (m_act) begin
          if (rx_valid) begin
            if (m_nb < 4) begin
              m_len[8*m_nb +: 8] = rx_data;
              m_xor = m_xor ^ rx_data;
              m_nb++;
              if (m_nb == 4 && m_len > MAXW) begin
                m_act = 0; m_err = 1;
              end
            end else if (longint'(m_nb) < 4 + 4 * longint'(m_len)) begin
              m_word[8*((m_nb - 4) % 4) +: 8] = rx_data;
              m_xor = m_xor ^ rx_data;
              m_nb++;
              if ((m_nb - 4) % 4 == 0) begin
                m_we    = 1;
                m_addr  = BASE + 32'(4 * int'(m_words));
                m_wd    = m_word;
                m_words = m_words + 16'd1;
              end
            end else begin
              m_act = 0;
              if (rx_data == m_xor) m_done = 1;
              else                  m_err  = 1;
            end
          end
        end else if (start) begin
          m_act = 1; m_done = 0; m_err = 0;
          m_nb = 0; m_len = 32'd0; m_word = 32'd0; m_xor = 8'd0; m_words = 16'd0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_imem_we",  32'(imem_we),  32'd0);
        chk("rst_addr",     imem_addr,     BASE);
        chk("rst_wd",       imem_wd,       32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_error",    32'(error),    32'd0);
        chk("rst_words",    32'(words_loaded), 32'd0);
      end else begin
        chk("rx_ready",  32'(rx_ready), 32'(m_act));
        chk("busy",      32'(busy),     32'(m_act));
        chk("done",      32'(done),     32'(m_done));
        chk("error",     32'(error),    32'(m_err));
        chk("core_rst",  32'(core_rst), 32'(m_done));
        chk("imem_we",   32'(imem_we),  32'(m_we));
        chk("imem_addr", imem_addr,     m_addr);
        chk("imem_wd",   imem_wd,       m_wd);
        chk("words",     32'(words_loaded), 32'(m_words));
        if (imem_we) begin
          wr_addr.push_back(imem_addr);
          wr_data.push_back(imem_wd);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] stream[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (rx_ready) ok = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout at %0t: actual=rx_ready low required=byte %h accepted", $time, b);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gapmax);
    for (int i = lo; i < hi; i++) begin
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick();
      send_byte(stream[i]);
    end
  endtask

  task automatic set_nominal(input logic [7:0] csum);
    stream = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00, csum};
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_nominal_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
      chk({tag, "_data0"}, wr_data[0], 32'h0050_0093);
      chk({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
      chk({tag, "_data1"}, wr_data[1], 32'h00A0_0113);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Nominal load
    clear_log();
    set_nominal(8'h73);
    pulse_start();
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
    send_range(0, 13, 0);
    @(negedge clk);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_core_rst", 32'(core_rst), 32'd1);
    chk("nom_words", 32'(words_loaded), 32'd2);
    check_nominal_writes("nom");
    tick();

    // Restart from DONE, then bad checksum
    clear_log();
    set_nominal(8'h72);
    pulse_start();
    @(negedge clk);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_core_rst", 32'(core_rst), 32'd0);
    tick();
    send_range(0, 13, 0);
    repeat (2) tick();
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_core_rst", 32'(core_rst), 32'd0);
    chk("bad_rx_ready", 32'(rx_ready), 32'd0);
    check_nominal_writes("bad");

    // Oversize count: 1025 words
    clear_log();
    stream = '{8'h01, 8'h04, 8'h00, 8'h00};
    pulse_start();
    chk("ovr_error_clear", 32'(error), 32'd0);
    send_range(0, 4, 0);
    chk("ovr_error", 32'(error), 32'd1);
    chk("ovr_rx_ready", 32'(rx_ready), 32'd0);
    repeat (4) tick();
    chk("ovr_nwrites", 32'(wr_addr.size()), 32'd0);

    // Empty load
    clear_log();
    stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_range(0, 5, 0);
    repeat (2) tick();
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_core_rst", 32'(core_rst), 32'd1);
    chk("empty_words", 32'(words_loaded), 32'd0);
    chk("empty_nwrites", 32'(wr_addr.size()), 32'd0);

    // Nominal stream with random rx_valid gaps
    clear_log();
    set_nominal(8'h73);
    pulse_start();
    send_range(0, 13, 5);
    repeat (2) tick();
    chk("gap_done", 32'(done), 32'd1);
    check_nominal_writes("gap");

    // Reset after the 5th data byte, then a full reload
    clear_log();
    pulse_start();
    send_range(0, 9, 2);
    rst = 1'b0;
    #1;
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    clear_log();
    pulse_start();
    send_range(0, 13, 0);
    repeat (2) tick();
    chk("reload_done", 32'(done), 32'd1);
    check_nominal_writes("reload");

    // start pulsed in DATA is ignored
    clear_log();
    pulse_start();
    send_range(0, 7, 0);
    pulse_start();
    chk("ign_busy", 32'(busy), 32'd1);
    send_range(7, 13, 0);
    repeat (2) tick();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_core_rst", 32'(core_rst), 32'd1);
    check_nominal_writes("ign");

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
